// File: rtl/arbitro_mux_memoria_pkg.sv
// arbitro_mux_memoria_pkg: shared state encoding and widths for the arbiter
package arbitro_mux_memoria_pkg;
  localparam int DATA_WIDTH_DEF = 2;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;
endpackage

// File: rtl/arbitro_mux_memoria_registro_salida_hs.sv
// registro_salida_hs: one-entry valid/ready output register with same-cycle drain and reload
module registro_salida_hs #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_out_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         slot_free_o
);
  logic [W-1:0] data_q;
  logic         valid_q;
  assign slot_free_o = !valid_q || ready_out_i;
  assign data_o = data_q;
  assign valid_o = valid_q;
  // load wins over drain so a simultaneous drain+load keeps the entry full
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_out_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/arbitro_mux_memoria.sv
// arbitro_mux_memoria: round-robin burst-limited arbiter driving a 2:1 memory mux; ARB_CONTADORES_EN adds per-requester accept counters
module arbitro_mux_memoria
  import arbitro_mux_memoria_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in0,
  input  logic [DATA_WIDTH-1:0] data_in0,
  output logic                  ready_in0,
  input  logic                  valid_in1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  output logic                  ready_in1,
  output logic                  selector,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
`ifdef ARB_CONTADORES_EN
  output logic [CNT_W-1:0]      cnt0,
  output logic [CNT_W-1:0]      cnt1,
`endif
  input  logic                  ready_out
);
  localparam logic [CNT_W-1:0] MB = CNT_W'(MAX_BURST);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             last_q, last_d, sel_q, sel_d;
  logic             slot_free, acc0, acc1, acc, g1, own_v, oth_v;
  assign g1 = state_q == ST_GNT1;
  assign own_v = g1 ? valid_in1 : valid_in0;
  assign oth_v = g1 ? valid_in0 : valid_in1;
  assign acc0 = valid_in0 && ready_in0;
  assign acc1 = valid_in1 && ready_in1;
  assign acc = acc0 || acc1;
  assign selector = sel_q;
  // state, burst count, round-robin pointer and mux select registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end
  // next-state: owner drop first, then burst-limit handover; burst saturates when unopposed
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (state_q == ST_IDLE) begin
      state_d = (valid_in0 && valid_in1) ? (last_q ? ST_GNT0 : ST_GNT1) :
                valid_in0 ? ST_GNT0 : valid_in1 ? ST_GNT1 : ST_IDLE;
    end else if (!own_v) begin
      state_d = oth_v ? (g1 ? ST_GNT0 : ST_GNT1) : ST_IDLE;
      burst_d = '0;
    end else if (acc && oth_v && burst_q >= MB - 1'b1) begin
      state_d = g1 ? ST_GNT0 : ST_GNT1;
      burst_d = '0;
    end else if (acc) begin
      burst_d = (burst_q < MB) ? burst_q + 1'b1 : burst_q;
    end
  end
  // outputs: only the owner sees ready, and only when the output slot can take a word
  always_comb begin
    ready_in0 = !reset && state_q == ST_GNT0 && slot_free;
    ready_in1 = !reset && g1 && slot_free;
    last_d = acc1 ? 1'b1 : acc0 ? 1'b0 : last_q;
    sel_d = (state_d == ST_IDLE) ? sel_q : state_d == ST_GNT1;
  end
  registro_salida_hs #(.W(DATA_WIDTH)) u_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (acc),
    .data_i     (acc1 ? data_in1 : data_in0),
    .ready_out_i(ready_out),
    .data_o     (data_out),
    .valid_o    (valid_out),
    .slot_free_o(slot_free)
  );
`ifdef ARB_CONTADORES_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
  // saturating accepted-word counters per requester
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0 && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
      if (acc1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_arbitro_mux_memoria.sv
// tb_arbitro_mux_memoria: directed self-checking bench for the round-robin memory mux arbiter
module tb_arbitro_mux_memoria;
  import arbitro_mux_memoria_pkg::*;
  logic       clk = 1'b0, reset = 1'b1, valid_in0 = 1'b0, valid_in1 = 1'b0, ready_out = 1'b1;
  logic [1:0] data_in0 = '0, data_in1 = '0;
  logic       ready_in0, ready_in1, selector, valid_out;
  logic [1:0] data_out;
`ifdef ARB_CONTADORES_EN
  logic [3:0] cnt0, cnt1;
`endif
  int vecs = 0, miss = 0;
  logic [1:0] prev, pat;
  logic       first, own;
  arbitro_mux_memoria dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in0(valid_in0),
    .data_in0 (data_in0),
    .ready_in0(ready_in0),
    .valid_in1(valid_in1),
    .data_in1 (data_in1),
    .ready_in1(ready_in1),
    .selector (selector),
    .data_out (data_out),
    .valid_out(valid_out),
`ifdef ARB_CONTADORES_EN
    .cnt0     (cnt0),
    .cnt1     (cnt1),
`endif
    .ready_out(ready_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  initial begin
    go();
    go();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_selector", selector, 0);
    chk("rst_ready0", ready_in0, 0);
    chk("rst_ready1", ready_in1, 0);
    chk("rst_state", dut.state_q, ST_IDLE);
    reset = 1'b0;
    valid_in0 = 1'b1;
    data_in0 = 2'b01;
    #1 chk("idle_ready0", ready_in0, 0);
    go();
    chk("r0_state", dut.state_q, ST_GNT0);
    chk("r0_sel", selector, 0);
    chk("r0_ready0", ready_in0, 1);
    go();
    chk("r0_w1", data_out, 2'b01);
    chk("r0_v1", valid_out, 1);
    data_in0 = 2'b10;
    go();
    chk("r0_w2", data_out, 2'b10);
    data_in0 = 2'b11;
    go();
    chk("r0_w3", data_out, 2'b11);
    chk("r0_v3", valid_out, 1);
    valid_in0 = 1'b0;
    go();
    chk("r0_idle", dut.state_q, ST_IDLE);
    chk("r0_drained", valid_out, 0);
    chk("r0_sel_hold", selector, 0);
    reset = 1'b1;
    go();
    reset = 1'b0;
    valid_in0 = 1'b1;
    valid_in1 = 1'b1;
    go();
    first = 1'b1;
    prev = '0;
    for (int r = 0; r < 3; r++) begin
      own = r[0];
      for (int k = 0; k < 4; k++) begin
        pat = 2'(k + r + 1);
        if (own) data_in1 = pat; else data_in0 = pat;
        #1;
        chk("rr_sel", selector, own);
        chk("rr_ready0", ready_in0, !own);
        chk("rr_ready1", ready_in1, own);
        if (!first) chk("rr_data", data_out, prev);
        first = 1'b0;
        prev = pat;
        go();
      end
    end
    chk("rr_last_data", data_out, prev);
    chk("rr_end_sel", selector, 1);
    chk("rr_end_state", dut.state_q, ST_GNT1);
    valid_in1 = 1'b0;
    go();
    chk("drop_state", dut.state_q, ST_GNT0);
    chk("drop_sel", selector, 0);
    chk("drop_burst", dut.burst_q, 0);
    chk("drop_vout", valid_out, 0);
    data_in0 = 2'b10;
    #1 chk("bp_ready_pre", ready_in0, 1);
    go();
    chk("bp_load", data_out, 2'b10);
    ready_out = 1'b0;
    data_in0 = 2'b11;
    #1 chk("bp_ready_blocked", ready_in0, 0);
    for (int i = 0; i < 3; i++) begin
      go();
      chk("bp_hold_data", data_out, 2'b10);
      chk("bp_hold_valid", valid_out, 1);
      chk("bp_hold_ready", ready_in0, 0);
    end
    ready_out = 1'b1;
    #1 chk("bp_ready_release", ready_in0, 1);
    go();
    chk("bp_reload_data", data_out, 2'b11);
    chk("bp_reload_valid", valid_out, 1);
    reset = 1'b1;
    #1 chk("rst_mid_ready0", ready_in0, 0);
    go();
    reset = 1'b0;
    valid_in1 = 1'b1;
    chk("rst_mid_valid", valid_out, 0);
    chk("rst_mid_data", data_out, 0);
    chk("rst_mid_state", dut.state_q, ST_IDLE);
    go();
    chk("tie_state", dut.state_q, ST_GNT0);
    chk("tie_sel", selector, 0);
    chk("tie_ready0", ready_in0, 1);
    chk("tie_ready1", ready_in1, 0);
    valid_in0 = 1'b0;
    go();
    chk("hand_state", dut.state_q, ST_GNT1);
    chk("hand_sel", selector, 1);
    valid_in1 = 1'b0;
    go();
    chk("idle_state", dut.state_q, ST_IDLE);
    chk("idle_sel_hold", selector, 1);
`ifdef ARB_CONTADORES_EN
    chk("cnt0_zero", cnt0, 0);
    chk("cnt1_zero", cnt1, 0);
    valid_in0 = 1'b1;
    data_in0 = 2'b01;
    repeat (22) go();
    chk("cnt0_sat", cnt0, 4'hf);
    chk("cnt1_idle", cnt1, 0);
    reset = 1'b1;
    go();
    reset = 1'b0;
    chk("cnt0_clr", cnt0, 0);
    chk("cnt1_clr", cnt1, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
